spin_wheel: RTL and testbench
=============================

# spin_wheel

Eight-slot spin controller for the Le-Adogo wheel. It sits directly downstream of the free-running 10-bit counter and samples that counter's value as its random seed when a spin is requested. It then steps a lit position around 8 slots at a fast rate, decelerates over the final lap, and stops on a seed-derived slot. It reports the result with a one-cycle done pulse to the game/display logic.

## Interface
- MIN_LAPS, 2, full laps always run before the final lap/offset; legal 1..20
- FAST_TICKS, 16'd50, ticks per step while cruising; legal ≥1
- SLOW_INC, 16'd25, extra ticks added per step during deceleration; legal ≥0
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low; clock clk
- tick  in  1  time-base strobe, one clk wide; ignored in IDLE
- rnd  in  10  free-running counter value (seed source)
- start  in  1  spin request, one clk wide, already debounced
- pos  out  3  currently lit slot 0..7
- busy  out  1  high while spinning
- done  out  1  one-cycle pulse when wheel stops
- result  out  3  final slot of last spin, held until next spin ends

## Operation
- States: IDLE, SPIN. All outputs and internal registers are 0 on reset: pos=0, busy=0, done=0, result=0, state=IDLE.
- IDLE, start=1 at a clk edge:
  - latch seed=rnd on that edge
  - target=seed[2:0], extra=seed[4:3]
  - remaining (8 bits) = 8*(MIN_LAPS+extra) + ((target − pos) mod 8)
  - dwell_cnt (16 bits) = 0; state→SPIN; busy→1
- Remaining is always ≥8, so a spin never has zero steps. Maximum is 8*23+7=191, which fits in 8 bits.
- Dwell for the current step:
  - FAST_TICKS if remaining > 8
  - else FAST_TICKS + SLOW_INC*(9 − remaining)
  - At remaining=8 the extra is +1·SLOW_INC; at remaining=1 it is +8·SLOW_INC.
  - Computed 16 bits wide. Parameters must keep the result ≤ 65535.
- SPIN, on tick=1:
  - if dwell_cnt == dwell−1: pos←pos+1 (mod 8, 7→0 wraps), remaining←remaining−1, dwell_cnt←0
  - else dwell_cnt←dwell_cnt+1
- No change in SPIN when tick=0.
- Final step (remaining==1 and step fires), all on the same edge:
  - pos←pos+1, result←pos+1, done←1, busy←0, state→IDLE
- done is high for exactly one cycle; it is cleared on the next edge.
- start while busy=1 is ignored. This includes the cycle of the final step, because busy is still 1 at that edge.
- start in the cycle after done (IDLE) is accepted normally.
- The seed is taken only at the start edge. Later changes on rnd have no effect.
- reset low at any time, mid-spin included: immediate return to reset values; the spin is abandoned with no done.
- pos in IDLE holds the last result, so the next spin starts from there.

## Timing
- start sampled at edge N → busy=1 after edge N. Tick at edge N itself is not counted.
- Each step takes exactly dwell ticks. Tick spacing is irrelevant, and tick=1 every cycle is legal.
- done, result and busy=0 all become visible after the edge of the final step. pos already shows result in that cycle.
- Total ticks per spin = Σ dwell over all steps (example below).

## Test plan
- MIN_LAPS=2, FAST_TICKS=2, SLOW_INC=1, tick=1 every cycle, pos=0, start with rnd=10'h005:
  - remaining=21, steps dwell 2 ×13 then 3..10
  - done exactly 78 cycles after busy rises; result=5, pos=5, busy=0
- Then start with rnd=10'h01A (extra=3, target=2) from pos=5:
  - remaining=45
  - ends with result=2, pos=2, one done pulse
- rnd=10'h000 from pos=0: remaining=16, result=0, pos visibly wraps 7→0 twice.
- Pulse start every cycle while busy, and also in the final-step cycle:
  - no restart, remaining unaffected
  - start one cycle after done is accepted
- Assert reset low mid-spin (pos≠0), release:
  - pos=0, busy=0, done=0, result=0, no done pulse
  - next spin behaves as in scenario 1
- Change rnd randomly during a spin, and gate tick (1 in 4 cycles): result depends only on rnd at the start edge. Cycle count = 4× the tick count; pos holds between ticks.

Source files
------------

// File: rtl/spin_wheel.sv
// spin_wheel: eight-slot spin controller for the Le-Adogo wheel.
// Samples the free-running counter as a seed on start, steps the lit slot
// around the wheel at a cruise rate, slows down over the final lap and stops
// on the seed-selected slot, then pulses done for one cycle.
//
// Ports:
//   clk     - system clock
//   reset   - asynchronous, active-low reset
//   tick    - time-base strobe, one clk wide (ignored while idle)
//   rnd     - free-running counter value used as the seed
//   start   - spin request, one clk wide
//   pos     - currently lit slot 0..7
//   busy    - high while spinning
//   done    - one-cycle pulse when the wheel stops
//   result  - final slot of the last completed spin
module spin_wheel #(
    parameter int unsigned MIN_LAPS   = 2,
    parameter logic [15:0] FAST_TICKS = 16'd50,
    parameter logic [15:0] SLOW_INC   = 16'd25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [9:0] rnd,
    input  logic       start,
    output logic [2:0] pos,
    output logic       busy,
    output logic       done,
    output logic [2:0] result
);

    localparam int unsigned POS_W   = 3;
    localparam int unsigned REM_W   = 8;
    localparam int unsigned DWELL_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SPIN = 1'b1
    } state_e;

    state_e               state_q,     state_d;
    logic [POS_W-1:0]     pos_q,       pos_d;
    logic [POS_W-1:0]     result_q,    result_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic [REM_W-1:0]     remaining_q, remaining_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;

    logic [REM_W-1:0]     laps_c;
    logic [POS_W-1:0]     offset_c;
    logic [DWELL_W-1:0]   slow_mult_c;
    logic [DWELL_W-1:0]   dwell_c;

    // Only the low five seed bits select target and extra laps.
    logic unused_rnd_c;
    assign unused_rnd_c = ^rnd[9:5];

    // Dwell of the current step: cruise rate, plus a growing slowdown
    // over the last eight steps (1x SLOW_INC at remaining=8 up to 8x at 1).
    always_comb begin
        slow_mult_c = '0;
        if (remaining_q <= REM_W'(8)) begin
            slow_mult_c = DWELL_W'(REM_W'(9) - remaining_q);
        end
        dwell_c = FAST_TICKS + (SLOW_INC * slow_mult_c);
    end

    // Step count for a new spin: whole laps plus forward distance to target.
    always_comb begin
        laps_c   = REM_W'(MIN_LAPS) + REM_W'(rnd[4:3]);
        offset_c = rnd[2:0] - pos_q;
    end

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        result_d    = result_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        dwell_cnt_d = dwell_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = {laps_c[4:0], 3'b000} + {5'b00000, offset_c};
                    dwell_cnt_d = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_SPIN;
                end
            end
            ST_SPIN: begin
                if (tick) begin
                    if (dwell_cnt_q == (dwell_c - DWELL_W'(1))) begin
                        pos_d       = pos_q + POS_W'(1);
                        remaining_d = remaining_q - REM_W'(1);
                        dwell_cnt_d = '0;
                        // Last step lands on the target slot.
                        if (remaining_q == REM_W'(1)) begin
                            result_d = pos_q + POS_W'(1);
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign pos    = pos_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_spin_wheel.sv
// Directed bench for spin_wheel with FAST_TICKS=2, SLOW_INC=1, MIN_LAPS=2.
module tb_spin_wheel;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic       start = 1'b0;
    logic [9:0] rnd   = '0;
    logic [2:0] pos;
    logic [2:0] result;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int model_pos = 0;

    spin_wheel #(
        .MIN_LAPS  (2),
        .FAST_TICKS(16'd2),
        .SLOW_INC  (16'd1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .rnd   (rnd),
        .start (start),
        .pos   (pos),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Total ticks for a spin of the given step count (cruise 2, slowdown +1..+8).
    function automatic int model_ticks(input int steps);
        int t;
        t = 0;
        for (int r = steps; r >= 1; r--) begin
            if (r > 8) t += 2;
            else       t += 2 + (9 - r);
        end
        return t;
    endfunction

    // Idle cycles: ticks are ignored, outputs hold.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            tick  = 1'b1;
            @(posedge clk);
            #1;
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_pos", pos, model_pos);
        end
    endtask

    task automatic run_spin(input logic [9:0] seed, input int period, input bit hammer,
                            input bit scramble, input string tag);
        int steps, exp_res, exp_t, exp_wraps;
        int c, ticks, nsteps, wraps;
        logic [2:0] prev;
        bit ticked, got_done;

        exp_res   = int'(seed[2:0]);
        steps     = 8 * (2 + int'(seed[4:3])) + ((exp_res - model_pos + 8) % 8);
        exp_t     = model_ticks(steps);
        exp_wraps = (model_pos + steps) / 8;

        @(negedge clk);
        start = 1'b1;
        rnd   = seed;
        tick  = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_done_low"}, done, 0);
        check({tag, "_pos_start"}, pos, model_pos);

        prev = 3'(model_pos);
        c = 0; ticks = 0; nsteps = 0; wraps = 0; got_done = 0;
        while (!got_done && c < 5000) begin
            @(negedge clk);
            ticked = (period == 1) || ((c % period) == (period - 1));
            tick   = ticked;
            start  = hammer;
            if (scramble) rnd = 10'($urandom);
            @(posedge clk);
            #1;
            c++;
            if (ticked) ticks++;
            if (!ticked) begin
                check({tag, "_hold"}, pos, prev);
            end else if (pos != prev) begin
                nsteps++;
                check({tag, "_step"}, pos, 3'(prev + 3'd1));
                if (prev == 3'd7) wraps++;
            end
            prev = pos;
            if (done) got_done = 1;
            else if (busy !== 1'b1) begin
                check({tag, "_busy_mid"}, busy, 1);
                got_done = 1;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_ticks"}, ticks, exp_t);
        check({tag, "_cycles"}, c, period * exp_t);
        check({tag, "_steps"}, nsteps, steps);
        check({tag, "_wraps"}, wraps, exp_wraps);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_pos_end"}, pos, exp_res);
        check({tag, "_busy_end"}, busy, 0);
        model_pos = exp_res;
    endtask

    initial begin
        // Power-on reset
        #3 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_pos", pos, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        reset = 1'b1;
        model_pos = 0;
        idle_cycles(2);

        // Scenario 1: seed 5 from slot 0, 21 steps, 78 ticks
        run_spin(10'h005, 1, 1'b0, 1'b0, "s1");
        idle_cycles(2);

        // Scenario 2: seed 0x1A from slot 5, start hammered incl. final step
        run_spin(10'h01A, 1, 1'b1, 1'b0, "s2");
        // Start in the done cycle is accepted
        run_spin(10'h00D, 1, 1'b0, 1'b0, "s2b");
        idle_cycles(1);

        // Reset mid-spin: seed 0x1F from slot 5, 15 steps in then reset
        @(negedge clk);
        start = 1'b1;
        rnd   = 10'h01F;
        tick  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_pos", pos, 4);
        check("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_pos", pos, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("mid_rst_no_done", done, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        model_pos = 0;
        idle_cycles(2);

        // Spin after reset matches scenario 1
        run_spin(10'h005, 1, 1'b0, 1'b0, "s5");
        idle_cycles(1);

        // Back to slot 0, then seed 0: 16 steps, two 7->0 wraps
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_pos = 0;
        idle_cycles(1);
        run_spin(10'h000, 1, 1'b0, 1'b0, "s3");
        idle_cycles(1);

        // Gated tick (1 in 4) with rnd scrambled during the spin
        run_spin(10'h01A, 4, 1'b0, 1'b1, "s6");
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
